// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and defaults for the multiplexed 7-segment scan controller.
// Holds the scan FSM encoding, the default geometry/timing and a small helper function.
package display_scan_ctrl_pkg;

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  localparam int DEF_NUM_DIGITS  = 4;
  localparam int DEF_REFRESH_DIV = 50000;
  localparam int DEF_GUARD_CYC   = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// Interval timer shared by the GUARD and DRIVE phases: restarts from zero on terminal count.
// tc is high on the last cycle of an interval of length len_m1+1.
module display_scan_ctrl_scan_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] len_m1,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == len_m1);

  // Every terminal count is also a state change, so the count clears there.
  always_comb begin
    cnt_d = tc ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Scans NUM_DIGITS hex digits through one shared 7-segment encoder with guard gaps,
// leading-zero blanking and a frame-synchronous double buffer for the displayed value.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int GUARD_CYC   = DEF_GUARD_CYC
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    blank_en,
  output logic [3:0]              enc_in,
  output logic                    enc_enable,
  output logic [NUM_DIGITS-1:0]   digit_an,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(max_int(REFRESH_DIV, GUARD_CYC));
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] DRIVE_M1 = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_M1 = CNT_W'(GUARD_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic                    pending_q, pending_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [3:0]              enc_in_q, enc_in_d;
  logic                    enc_en_q, enc_en_d;
  logic                    frame_done_q, frame_done_d;

  logic                    tc;
  logic [CNT_W-1:0]        len_m1;
  logic                    boundary;
  logic                    upper_zero;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   sel_an;
  logic [3:0]              cur_nib;
  logic                    cur_blank;

  assign len_m1   = (state_q == ST_DRIVE) ? DRIVE_M1 : GUARD_M1;
  assign boundary = (state_q == ST_DRIVE) && tc && (idx_q == LAST_IDX);

  display_scan_ctrl_scan_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .len_m1 (len_m1),
    .tc     (tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_GUARD;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (tc) begin
      if (state_q == ST_GUARD) begin
        state_d = ST_DRIVE;
      end else begin
        state_d = ST_GUARD;
        idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
    end
  end

  // Digit i>0 is blankable when it and every more-significant nibble are zero.
  always_comb begin
    upper_zero = 1'b1;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero    = upper_zero && (active_q[4*i +: 4] == 4'h0);
      blank_mask[i] = upper_zero;
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_blank = 1'b0;
    sel_an    = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = active_q[4*i +: 4];
        cur_blank = blank_en && blank_mask[i];
        sel_an[i] = 1'b0;
      end
    end
    if (cur_blank) sel_an = '1;
  end

  // Outputs are precomputed for the state being entered so they switch with it.
  always_comb begin
    an_d         = an_q;
    enc_in_d     = enc_in_q;
    enc_en_d     = enc_en_q;
    frame_done_d = boundary;
    if (tc) begin
      if (state_q == ST_GUARD) begin
        an_d     = sel_an;
        enc_in_d = cur_nib;
        enc_en_d = !cur_blank;
      end else begin
        an_d     = '1;
        enc_en_d = 1'b0;
      end
    end
  end

  // A load coinciding with the frame boundary bypasses the shadow straight into active.
  always_comb begin
    shadow_d  = load ? value_in : shadow_q;
    pending_d = load || pending_q;
    active_d  = active_q;
    if (boundary && (pending_q || load)) begin
      active_d  = load ? value_in : shadow_q;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      an_q         <= '1;
      enc_in_q     <= 4'h0;
      enc_en_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      enc_in_q     <= enc_in_d;
      enc_en_q     <= enc_en_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign digit_an   = an_q;
  assign enc_in     = enc_in_q;
  assign enc_enable = enc_en_q;
  assign frame_done = frame_done_q;

endmodule
